// File: rtl/dmem_lsu_pkg.sv
// dmem_lsu_pkg: shared access-size codes and default geometry for the data-memory LSU
package dmem_lsu_pkg;
    typedef enum logic [1:0] {SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2, SZ_D = 2'd3} size_e;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 14;
    localparam int LANE_W     = 8;
endpackage

// File: rtl/dmem_bank.sv
// dmem_bank: one byte lane of the data RAM, synchronous read, block-RAM style
module dmem_bank import dmem_lsu_pkg::*; #(
    parameter int AW = 12
) (
    input  logic              clka,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [LANE_W-1:0] wd,
    output logic [LANE_W-1:0] rd
);
    logic [LANE_W-1:0] mem [2**AW];
    // Lane write on enable; the read register samples the addressed entry every cycle
    always_ff @(posedge clka) begin
        if (we) mem[addr] <= wd;
        rd <= mem[addr];
    end
endmodule

// File: rtl/dmem_lsu.sv
// dmem_lsu: byte-lane data memory with load/store steering, extension, credits and in-order response FIFO
module dmem_lsu import dmem_lsu_pkg::*; #(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int OUT_REG = 0
) (
    input  logic              clka,
    input  logic              rsta,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);
    localparam int NL  = DATA_W / LANE_W;
    localparam int LB  = $clog2(NL);
    localparam int AW  = ADDR_W - LB;
    localparam int DB  = $clog2(DATA_W);
    localparam int LAT = 1 + OUT_REG;
    localparam int CAP = LAT + 1;
    localparam int PW  = $clog2(CAP);

    typedef struct packed {
        logic              err;
        logic [DATA_W-1:0] d;
    } rsp_t;

    logic [LB-1:0]     off, s1_off;
    logic [3:0]        nbytes;
    logic [7:0]        nbits;
    logic [NL-1:0]     lanes;
    logic [DATA_W-1:0] wrep, rdw, sh, keep, ld;
    logic [2:0]        occ, cnt;
    logic [PW-1:0]     wp, rp;
    logic [1:0]        s1_size;
    logic              err, fire, rsp_fire, push, pop, empty, in_v;
    logic              s1_v, s1_we, s1_err, s1_uns;
    rsp_t              st, in_r, head;
    rsp_t              fq [2**PW];

    assign off       = req_addr[LB-1:0];
    assign nbytes    = 4'd1 << req_size;
    assign err       = (req_size > 2'(LB)) || ((off & LB'(nbytes - 4'd1)) != '0);
    assign lanes     = NL'((16'd1 << nbytes) - 16'd1) << off;
    assign req_ready = occ < 3'(CAP);
    assign fire      = req_valid && req_ready;

    // Replicate the right-aligned store bytes across all lanes; lane enables select the live ones
    always_comb begin
        wrep = '0;
        for (int i = 0; i < NL; i++)
            wrep[LANE_W*i +: LANE_W] = req_wdata[LANE_W*(i & (int'(nbytes) - 1)) +: LANE_W];
    end

    for (genvar i = 0; i < NL; i++) begin : g_lane
        dmem_bank #(.AW(AW)) u_bank (
            .clka (clka),
            .we   (fire && req_we && !err && lanes[i]),
            .addr (req_addr[ADDR_W-1:LB]),
            .wd   (wrep[LANE_W*i +: LANE_W]),
            .rd   (rdw[LANE_W*i +: LANE_W])
        );
    end

    // Request metadata travels alongside the synchronous RAM read
    always_ff @(posedge clka or negedge rsta) begin
        if (!rsta) begin
            s1_v    <= 1'b0;
            s1_we   <= 1'b0;
            s1_err  <= 1'b0;
            s1_uns  <= 1'b0;
            s1_size <= 2'd0;
            s1_off  <= '0;
        end else begin
            s1_v    <= fire;
            s1_we   <= req_we;
            s1_err  <= err;
            s1_uns  <= req_unsigned;
            s1_size <= req_size;
            s1_off  <= off;
        end
    end

    // Shift the read word down to the access, keep its width, then sign- or zero-extend
    always_comb begin
        sh     = rdw >> {s1_off, 3'b000};
        nbits  = (8'd8 << s1_size) > 8'(DATA_W) ? 8'(DATA_W) : 8'd8 << s1_size;
        keep   = {DATA_W{1'b1}} >> (8'(DATA_W) - nbits);
        ld     = (sh & keep) | ((!s1_uns && sh[DB'(nbits - 8'd1)]) ? ~keep : '0);
        st.err = s1_err;
        st.d   = (s1_we || s1_err) ? '0 : ld;
    end

    if (OUT_REG != 0) begin : g_oreg
        rsp_t s2_r;
        logic s2_v;
        // Optional output register adds one cycle between RAM and the response FIFO
        always_ff @(posedge clka or negedge rsta) begin
            if (!rsta) begin
                s2_v <= 1'b0;
                s2_r <= '0;
            end else begin
                s2_v <= s1_v;
                s2_r <= st;
            end
        end
        assign in_v = s2_v;
        assign in_r = s2_r;
    end else begin : g_nreg
        assign in_v = s1_v;
        assign in_r = st;
    end

    assign empty     = cnt == 3'd0;
    assign head      = empty ? in_r : fq[rp];
    assign rsp_valid = !empty || in_v;
    assign rsp_rdata = rsp_valid ? head.d : '0;
    assign rsp_err   = rsp_valid && head.err;
    assign rsp_fire  = rsp_valid && rsp_ready;
    assign push      = in_v && !(empty && rsp_ready);
    assign pop       = !empty && rsp_ready;

    // Credits count in-flight plus buffered responses, so the FIFO can never overflow
    always_ff @(posedge clka or negedge rsta) begin
        if (!rsta) begin
            occ <= 3'd0;
            cnt <= 3'd0;
            wp  <= '0;
            rp  <= '0;
        end else begin
            occ <= occ + 3'(fire) - 3'(rsp_fire);
            cnt <= cnt + 3'(push) - 3'(pop);
            if (push) wp <= (wp == PW'(CAP - 1)) ? '0 : wp + 1'b1;
            if (pop) rp <= (rp == PW'(CAP - 1)) ? '0 : rp + 1'b1;
        end
    end

    // FIFO storage is only read behind the count, so it needs no reset
    always_ff @(posedge clka) begin
        if (push) fq[wp] <= in_r;
    end
endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: scoreboard bench driving 32-bit (OUT_REG 0/1) and 64-bit LSUs with identical request streams
module tb_dmem_lsu;
    import dmem_lsu_pkg::*;

    typedef struct packed {
        logic        e;
        logic [63:0] d;
    } exp_t;

    logic clka = 1'b0;
    always #5 clka = ~clka;

    logic        rsta, req_we, req_uns, rsp_ready, rr_mode, rr_fix;
    logic [1:0]  req_size;
    logic [13:0] req_addr;
    logic [63:0] req_wdata;
    logic [2:0]  rv, rdy, vld, err;
    logic [31:0] rd0, rd1;
    logic [63:0] rd2;
    logic [63:0] rdx [3];
    exp_t        q [3][$];
    logic [7:0]  mm [2][16384];
    int          n_cmp = 0, n_bad = 0;
    int          cap [3] = '{2, 3, 2};
    logic [2:0]  hv = '0;
    exp_t        hr [3];
    exp_t        mo, me;

    assign rdx[0] = {32'b0, rd0};
    assign rdx[1] = {32'b0, rd1};
    assign rdx[2] = rd2;

    dmem_lsu #(.DATA_W(32), .ADDR_W(14), .OUT_REG(0)) u0 (
        .clka(clka), .rsta(rsta), .req_valid(rv[0]), .req_ready(rdy[0]), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_uns), .req_addr(req_addr), .req_wdata(req_wdata[31:0]),
        .rsp_valid(vld[0]), .rsp_ready(rsp_ready), .rsp_rdata(rd0), .rsp_err(err[0]));
    dmem_lsu #(.DATA_W(32), .ADDR_W(14), .OUT_REG(1)) u1 (
        .clka(clka), .rsta(rsta), .req_valid(rv[1]), .req_ready(rdy[1]), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_uns), .req_addr(req_addr), .req_wdata(req_wdata[31:0]),
        .rsp_valid(vld[1]), .rsp_ready(rsp_ready), .rsp_rdata(rd1), .rsp_err(err[1]));
    dmem_lsu #(.DATA_W(64), .ADDR_W(14), .OUT_REG(0)) u2 (
        .clka(clka), .rsta(rsta), .req_valid(rv[2]), .req_ready(rdy[2]), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_uns), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(vld[2]), .rsp_ready(rsp_ready), .rsp_rdata(rd2), .rsp_err(err[2]));

    task automatic cmp(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Byte-array reference memory: w=0 models the 32-bit parts, w=1 the 64-bit part
    task automatic model(input int w, input logic we, input logic [1:0] sz, input logic uns,
                         input int a, input logic [63:0] wd, output exp_t e);
        int nb, dwb;
        logic [63:0] d;
        nb  = 1 << sz;
        dwb = (w != 0) ? 8 : 4;
        d   = '0;
        e.e = ((a % nb) != 0) || (nb > dwb);
        if (!e.e && we)
            for (int i = 0; i < nb; i++) mm[w][a+i] = wd[8*i +: 8];
        if (!e.e && !we) begin
            for (int i = 0; i < nb; i++) d[8*i +: 8] = mm[w][a+i];
            if (!uns && d[8*nb-1])
                for (int i = nb; i < dwb; i++) d[8*i +: 8] = 8'hFF;
        end
        e.d = d;
    endtask

    task automatic idle(input int n);
        rv = 3'b000;
        repeat (n) begin
            @(posedge clka);
            #1;
        end
    endtask

    task automatic send(input logic we, input logic [1:0] sz, input logic uns, input int a, input logic [63:0] wd);
        exp_t e32, e64;
        logic [2:0] f;
        model(0, we, sz, uns, a, wd, e32);
        model(1, we, sz, uns, a, wd, e64);
        req_we = we;
        req_size = sz;
        req_uns = uns;
        req_addr = 14'(a);
        req_wdata = wd;
        rv = 3'b111;
        for (int t = 0; t < 200 && rv != 3'b000; t++) begin
            f = rv & rdy;
            for (int k = 0; k < 3; k++) if (f[k]) q[k].push_back(k == 2 ? e64 : e32);
            @(posedge clka);
            #1;
            rv = rv & ~f;
        end
        cmp("send_accept", 65'(rv), 65'd0);
        rv = 3'b000;
    endtask

    task automatic drain();
        for (int t = 0; t < 500 && (q[0].size() + q[1].size() + q[2].size()) != 0; t++) begin
            @(posedge clka);
            #1;
        end
        for (int k = 0; k < 3; k++) cmp($sformatf("drain%0d", k), 65'(q[k].size()), 65'd0);
    endtask

    // Response ready: fixed level or random back-pressure
    initial begin
        rsp_ready = 1'b1;
        forever begin
            @(posedge clka);
            #1;
            rsp_ready = rr_mode ? 1'($urandom) : rr_fix;
        end
    end

    // Monitor: hold-stability while stalled, and in-order scoreboard compare on each response fire
    always @(negedge clka) begin
        if (!rsta) hv = '0;
        else for (int k = 0; k < 3; k++) begin
            mo = {err[k], rdx[k]};
            if (hv[k]) begin
                cmp($sformatf("hold_valid%0d", k), 65'(vld[k]), 65'd1);
                cmp($sformatf("hold_data%0d", k), mo, hr[k]);
            end
            if (vld[k] && rsp_ready) begin
                if (q[k].size() == 0) cmp($sformatf("spurious%0d", k), 65'(q[k].size()), 65'd1);
                else begin
                    me = q[k].pop_front();
                    cmp($sformatf("rsp%0d", k), mo, me);
                end
            end
            hv[k] = vld[k] && !rsp_ready;
            hr[k] = mo;
        end
    end

    initial begin
        #950000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc [3];
        int a;
        exp_t e32, e64;
        rsta = 1'b0;
        rv = 3'b000;
        req_we = 1'b0;
        req_size = 2'd0;
        req_uns = 1'b0;
        req_addr = '0;
        req_wdata = '0;
        rr_mode = 1'b0;
        rr_fix = 1'b1;
        #12;
        for (int k = 0; k < 3; k++) begin
            cmp($sformatf("rst_ready%0d", k), 65'(rdy[k]), 65'd1);
            cmp($sformatf("rst_valid%0d", k), 65'(vld[k]), 65'd0);
            cmp($sformatf("rst_rdata%0d", k), 65'(rdx[k]), 65'd0);
            cmp($sformatf("rst_err%0d", k), 65'(err[k]), 65'd0);
        end
        @(posedge clka);
        #1;
        rsta = 1'b1;
        idle(2);
        send(1, SZ_W, 0, 'h100, 64'hA1B2C3D4);
        send(0, SZ_B, 0, 'h103, 0);
        send(0, SZ_B, 1, 'h103, 0);
        send(0, SZ_H, 0, 'h102, 0);
        send(0, SZ_H, 1, 'h100, 0);
        send(1, SZ_W, 0, 'h200, 0);
        send(1, SZ_B, 0, 'h201, 64'h5A);
        send(0, SZ_W, 0, 'h200, 0);
        send(1, SZ_W, 0, 'h300, 64'h11223344);
        send(0, SZ_W, 0, 'h300, 0);
        send(0, SZ_H, 0, 'h101, 0);
        send(1, SZ_W, 0, 'h102, 64'hDEADBEEF);
        send(0, SZ_W, 0, 'h100, 0);
        send(1, SZ_W, 0, 'h308, 0);
        send(1, SZ_W, 0, 'h30C, 0);
        send(1, SZ_D, 0, 'h308, 64'h0123456789ABCDEF);
        send(1, SZ_D, 0, 'h304, 64'hFFFFFFFFFFFFFFFF);
        send(0, SZ_D, 0, 'h308, 0);
        send(0, SZ_W, 0, 'h308, 0);
        send(0, SZ_W, 1, 'h308, 0);
        send(0, SZ_W, 0, 'h30C, 0);
        drain();

        rr_fix = 1'b0;
        idle(2);
        acc = '{0, 0, 0};
        for (int j = 0; j < 5; j++) begin
            a = (j % 3 + 1) * 'h100;
            model(0, 0, SZ_W, 0, a, 0, e32);
            model(1, 0, SZ_W, 0, a, 0, e64);
            req_we = 1'b0;
            req_size = SZ_W;
            req_uns = 1'b0;
            req_addr = 14'(a);
            rv = 3'b111;
            for (int k = 0; k < 3; k++) if (rdy[k]) begin
                q[k].push_back(k == 2 ? e64 : e32);
                acc[k]++;
            end
            @(posedge clka);
            #1;
        end
        idle(3);
        for (int k = 0; k < 3; k++) begin
            cmp($sformatf("stall_accepted%0d", k), 65'(acc[k]), 65'(cap[k]));
            cmp($sformatf("stall_ready%0d", k), 65'(rdy[k]), 65'd0);
            cmp($sformatf("stall_valid%0d", k), 65'(vld[k]), 65'd1);
        end
        rr_fix = 1'b1;
        drain();
        idle(1);
        for (int k = 0; k < 3; k++) cmp($sformatf("resume_ready%0d", k), 65'(rdy[k]), 65'd1);
        send(0, SZ_W, 0, 'h300, 0);
        drain();

        rr_fix = 1'b0;
        idle(2);
        send(0, SZ_W, 0, 'h100, 0);
        send(0, SZ_W, 0, 'h200, 0);
        #2;
        rsta = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            cmp($sformatf("midrst_valid%0d", k), 65'(vld[k]), 65'd0);
            cmp($sformatf("midrst_ready%0d", k), 65'(rdy[k]), 65'd1);
            q[k].delete();
        end
        @(posedge clka);
        #1;
        rsta = 1'b1;
        rr_fix = 1'b1;
        idle(2);
        send(0, SZ_W, 0, 'h300, 0);
        send(0, SZ_W, 0, 'h100, 0);
        send(0, SZ_B, 0, 'h201, 0);
        drain();

        rr_mode = 1'b1;
        for (int b = 'h400; b < 'h440; b += 4) send(1, SZ_W, 0, b, {$urandom, $urandom});
        for (int n = 0; n < 10000; n++) begin
            if ($urandom_range(3) == 0) idle(1);
            send(1'($urandom), 2'($urandom), 1'($urandom), 'h400 + int'($urandom_range(63)), {$urandom, $urandom});
        end
        rr_mode = 1'b0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
